// File: rtl/data_bram_pkg.sv
// Shared defaults and width helpers for the banked ping-pong data buffer.
// Width constants are derived here so every file agrees on address sizing.
package data_bram_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 100;
  localparam int DEF_NUM_BANKS  = 2;

  // Minimum one bit so a single-entry range still gets a usable index.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ADDR_WIDTH = width_for(DEF_DEPTH);
  localparam int DEF_BANK_WIDTH = width_for(DEF_NUM_BANKS);

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array carries no reset so it maps onto block RAM.
module bram_sdp
  import data_bram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WORDS      = DEF_DEPTH * DEF_NUM_BANKS,
  parameter int AW         = width_for(DEF_DEPTH * DEF_NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/data_bank_bram.sv
// Multi-bank fill/drain buffer: the writer fills whole banks in turn, the reader
// reads filled banks at random addresses and releases them back to the writer.
module data_bank_bram
  import data_bram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BANK_WIDTH = DEF_BANK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  bank_done,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_release,
  output logic                  rd_avail,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [BANK_WIDTH:0]   fill_level,
  output logic                  err
);

  localparam int FLAT_WORDS = NUM_BANKS * DEPTH;
  localparam int FLAT_W     = width_for(FLAT_WORDS);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [BANK_WIDTH-1:0] LAST_BANK = BANK_WIDTH'(NUM_BANKS - 1);
  localparam logic [BANK_WIDTH:0]   FULL      = (BANK_WIDTH + 1)'(NUM_BANKS);

  logic [BANK_WIDTH-1:0] wb_q, wb_d, rb_q, rb_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [BANK_WIDTH:0]   fill_q, fill_d;
  logic                  err_q, err_d, done_q, done_d, rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d, mem_rdata;

  logic wr_in_range, rd_in_range, wr_ok, bank_fill, rd_ok, rel_ok;
  logic [FLAT_W-1:0] mem_waddr, mem_raddr;

  assign wr_ready   = (fill_q != FULL);
  assign rd_avail   = (fill_q != '0);
  assign bank_done  = done_q;
  assign rd_valid   = rd_valid_q;
  assign fill_level = fill_q;
  assign err        = err_q;
  // RAM output is only meaningful the cycle after a served read; otherwise show the held word.
  assign rd_data    = rd_valid_q ? mem_rdata : rd_hold_q;

  assign mem_waddr = FLAT_W'(wb_q) * FLAT_W'(DEPTH) + FLAT_W'(wr_addr);
  assign mem_raddr = FLAT_W'(rb_q) * FLAT_W'(DEPTH) + FLAT_W'(rd_addr);

  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
    wr_ok       = wr_en && wr_ready && wr_in_range && !clear;
    bank_fill   = wr_ok && (wcnt_q == LAST_WORD);
    rd_ok       = rd_en && rd_avail && rd_in_range && !clear;
    rel_ok      = rd_release && rd_avail && !clear;

    wb_d       = wb_q;
    rb_d       = rb_q;
    wcnt_d     = wcnt_q;
    fill_d     = fill_q;
    err_d      = err_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_hold_d  = rd_valid_q ? mem_rdata : rd_hold_q;

    if (clear) begin
      wb_d   = '0;
      rb_d   = '0;
      wcnt_d = '0;
      fill_d = '0;
      err_d  = 1'b0;
    end else begin
      done_d     = bank_fill;
      rd_valid_d = rd_ok;
      if ((wr_en && !(wr_ready && wr_in_range)) ||
          (rd_en && rd_avail && !rd_in_range) ||
          (rd_release && !rd_avail)) begin
        err_d = 1'b1;
      end
      if (wr_ok) begin
        wcnt_d = bank_fill ? '0 : wcnt_q + ADDR_WIDTH'(1);
      end
      if (bank_fill) begin
        wb_d = (wb_q == LAST_BANK) ? '0 : wb_q + BANK_WIDTH'(1);
      end
      if (rel_ok) begin
        rb_d = (rb_q == LAST_BANK) ? '0 : rb_q + BANK_WIDTH'(1);
      end
      // A completion and a release in the same cycle cancel in the count.
      case ({bank_fill, rel_ok})
        2'b10:   fill_d = fill_q + (BANK_WIDTH + 1)'(1);
        2'b01:   fill_d = fill_q - (BANK_WIDTH + 1)'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q       <= '0;
      rb_q       <= '0;
      wcnt_q     <= '0;
      fill_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      wcnt_q     <= wcnt_d;
      fill_q     <= fill_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_hold_q  <= rd_hold_d;
    end
  end

  bram_sdp #(
    .DATA_WIDTH(DATA_WIDTH),
    .WORDS     (FLAT_WORDS),
    .AW        (FLAT_W)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_ok),
    .wr_addr(mem_waddr),
    .wr_data(wr_data),
    .rd_en  (rd_ok),
    .rd_addr(mem_raddr),
    .rd_data(mem_rdata)
  );

endmodule

// File: tb/tb_data_bank_bram.sv
// Directed bench for data_bank_bram (DEPTH=4, two banks) with a queue-of-banks
// reference model checked every cycle plus hand-computed literal expectations.
module tb_data_bank_bram;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int NB = 2;
  localparam int AW = 3;
  localparam int BW = 1;

  logic          clk, rst, clear;
  logic          wr_en, rd_en, rd_release;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_ready, bank_done, rd_avail, rd_valid, err;
  logic [BW:0]   fill_level;

  data_bank_bram #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .BANK_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .bank_done(bank_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
    .rd_avail(rd_avail), .rd_data(rd_data), .rd_valid(rd_valid),
    .fill_level(fill_level), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Reference model: banks are whole units; filled banks wait in a FIFO for the reader.
  logic [DW-1:0] mm [NB][DEPTH];
  int            ready_q[$];
  int            cur_bank, cur_cnt;
  logic          e_err, e_done, e_valid;
  logic [DW-1:0] e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ready_q.delete();
    cur_bank = 0;
    cur_cnt  = 0;
    e_err    = 1'b0;
    e_done   = 1'b0;
    e_valid  = 1'b0;
    e_data   = '0;
  endtask

  task automatic model_step();
    int  sz, tmp;
    bit  avail, ready;
    if (clear) begin
      ready_q.delete();
      cur_bank = 0;
      cur_cnt  = 0;
      e_err    = 1'b0;
      e_done   = 1'b0;
      e_valid  = 1'b0;
      return;
    end
    sz      = ready_q.size();
    avail   = (sz != 0);
    ready   = (sz != NB);
    e_done  = 1'b0;
    e_valid = 1'b0;
    if (rd_en && avail) begin
      if (int'(rd_addr) < DEPTH) begin
        e_data  = mm[ready_q[0]][rd_addr];
        e_valid = 1'b1;
      end else begin
        e_err = 1'b1;
      end
    end
    if (wr_en) begin
      if (ready && int'(wr_addr) < DEPTH) begin
        mm[cur_bank][wr_addr] = wr_data;
        cur_cnt++;
        if (cur_cnt == DEPTH) begin
          ready_q.push_back(cur_bank);
          cur_bank = (cur_bank + 1) % NB;
          cur_cnt  = 0;
          e_done   = 1'b1;
        end
      end else begin
        e_err = 1'b1;
      end
    end
    if (rd_release) begin
      if (avail) tmp = ready_q.pop_front();
      else e_err = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("m_wr_ready", {31'b0, wr_ready}, {31'b0, ready_q.size() != NB});
      chk("m_rd_avail", {31'b0, rd_avail}, {31'b0, ready_q.size() != 0});
      chk("m_fill", {30'b0, fill_level}, ready_q.size());
      chk("m_err", {31'b0, err}, {31'b0, e_err});
      chk("m_bank_done", {31'b0, bank_done}, {31'b0, e_done});
      chk("m_rd_valid", {31'b0, rd_valid}, {31'b0, e_valid});
      chk("m_rd_data", rd_data, e_data);
    end
  end

  task automatic tick(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic re, input logic [AW-1:0] ra, input logic rel, input logic clr);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; rd_release = rel; clear = clr;
    model_step();
    $display("txn t=%0t we=%0b wa=%0d wd=%0h re=%0b ra=%0d rel=%0b clr=%0b", $time, we, wa, wd, re, ra, rel, clr);
    @(posedge clk);
    #3;
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    tick(1'b1, wa, wd, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] ra);
    tick(1'b0, '0, '0, 1'b1, ra, 1'b0, 1'b0);
  endtask

  task automatic idle();
    tick(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, {31'b0, wr_ready}, 32'd1);
    chk({tag, "_rd_avail"}, {31'b0, rd_avail}, 32'd0);
    chk({tag, "_fill"}, {30'b0, fill_level}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_rd_valid"}, {31'b0, rd_valid}, 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_bank_done"}, {31'b0, bank_done}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) mm[b][a] = '0;
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk_reset_outputs("por");
    rst = 1'b0;
    cmp_en = 1'b1;

    // Fill bank 0.
    for (int i = 0; i < 4; i++) wr(AW'(i), 32'hA0 + i);
    chk("fill0_done", {31'b0, bank_done}, 32'd1);
    chk("fill0_level", {30'b0, fill_level}, 32'd1);
    chk("fill0_avail", {31'b0, rd_avail}, 32'd1);
    chk("fill0_ready", {31'b0, wr_ready}, 32'd1);
    idle();
    chk("fill0_done_drop", {31'b0, bank_done}, 32'd0);

    // Fill bank 1, then an overflow write.
    for (int i = 0; i < 4; i++) wr(AW'(i), 32'hB0 + i);
    chk("full_ready", {31'b0, wr_ready}, 32'd0);
    chk("full_level", {30'b0, fill_level}, 32'd2);
    wr(3'd0, 32'hFF);
    chk("ovf_err", {31'b0, err}, 32'd1);
    rd(3'd0);
    chk("rd_a0_valid", {31'b0, rd_valid}, 32'd1);
    chk("rd_a0_data", rd_data, 32'hA0);

    // Read with release in the same cycle.
    tick(1'b0, '0, '0, 1'b1, 3'd2, 1'b1, 1'b0);
    chk("rel_rd_data", rd_data, 32'hA2);
    chk("rel_level", {30'b0, fill_level}, 32'd1);
    rd(3'd1);
    chk("rd_b1_data", rd_data, 32'hB1);
    idle();
    chk("hold_valid", {31'b0, rd_valid}, 32'd0);
    chk("hold_data", rd_data, 32'hB1);

    // Bank completion coincident with release.
    for (int i = 0; i < 3; i++) wr(AW'(i), 32'hC0 + i);
    tick(1'b1, 3'd3, 32'hC3, 1'b0, '0, 1'b1, 1'b0);
    chk("coinc_level", {30'b0, fill_level}, 32'd1);
    chk("coinc_done", {31'b0, bank_done}, 32'd1);
    rd(3'd3);
    chk("coinc_rd", rd_data, 32'hC3);

    // Reset in the middle of a fill, with a read in flight.
    wr(3'd0, 32'hD0);
    tick(1'b1, 3'd1, 32'hD1, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("pre_rst_data", rd_data, 32'hC0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) wr(AW'(i), 32'hE0 + i);
    chk("rst_no_early_done", {31'b0, bank_done}, 32'd0);
    wr(3'd3, 32'hE3);
    chk("rst_fill_done", {31'b0, bank_done}, 32'd1);
    rd(3'd2);
    chk("rst_rd_e2", rd_data, 32'hE2);

    // Protocol errors from an empty buffer, then clear.
    tick(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("drain_level", {30'b0, fill_level}, 32'd0);
    tick(1'b1, 3'd5, 32'h99, 1'b0, '0, 1'b1, 1'b0);
    chk("bad_err", {31'b0, err}, 32'd1);
    chk("bad_level", {30'b0, fill_level}, 32'd0);
    chk("bad_ready", {31'b0, wr_ready}, 32'd1);
    tick(1'b1, 3'd0, 32'h77, 1'b0, '0, 1'b0, 1'b1);
    chk("clr_err", {31'b0, err}, 32'd0);
    for (int i = 0; i < 4; i++) wr(3'd0, 32'hF0 + i);
    chk("refill_done", {31'b0, bank_done}, 32'd1);
    rd(3'd1);
    chk("keep_e1", rd_data, 32'hE1);
    rd(3'd0);
    chk("over_f3", rd_data, 32'hF3);
    rd(3'd7);
    chk("rd_oob_valid", {31'b0, rd_valid}, 32'd0);
    chk("rd_oob_err", {31'b0, err}, 32'd1);
    chk("rd_oob_hold", rd_data, 32'hF3);
    idle();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bank_bram.md
DATA_BANK_BRAM -- requirements
Module: data_bank_bram

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, word width; DEPTH, default 100, words per bank; NUM_BANKS, default 2, bank count (>=2); ADDR_WIDTH, default 7, in-bank address width (2^ADDR_WIDTH >= DEPTH); BANK_WIDTH, default 1, bank index width.
REQ-002 Ports SHALL be: clk input 1 single clock, all logic on rising edge.
REQ-003 rst input 1, asynchronous, active-high reset.
REQ-004 clear input 1, synchronous soft reset of control state.
REQ-005 wr_en input 1, write request; wr_addr input ADDR_WIDTH, in-bank write address; wr_data input DATA_WIDTH, write data.
REQ-006 wr_ready output 1, a free bank is open for writing.
REQ-007 bank_done output 1, one-cycle pulse when a bank completes filling.
REQ-008 rd_en input 1, read request; rd_addr input ADDR_WIDTH, in-bank read address; rd_release input 1, reader finished with current read bank.
REQ-009 rd_avail output 1, at least one filled bank; rd_data output DATA_WIDTH; rd_valid output 1, rd_data valid.
REQ-010 fill_level output BANK_WIDTH+1, number of filled banks; err output 1, sticky protocol error.

Function
REQ-011 Storage SHALL be NUM_BANKS x DEPTH words, flat index = bank*DEPTH + addr, no per-word reset.
REQ-012 State: write bank pointer wb, read bank pointer rb, per-write-bank word counter wcnt (0..DEPTH-1), fill_level (0..NUM_BANKS).
REQ-013 wr_ready = (fill_level != NUM_BANKS); rd_avail = (fill_level != 0), both combinational from registers.
REQ-014 Write accepted when wr_en && wr_ready && wr_addr < DEPTH: mem[wb][wr_addr] <= wr_data, wcnt+1.
REQ-015 On accepted write with wcnt == DEPTH-1: wcnt->0, wb->(wb+1) mod NUM_BANKS, fill_level+1, bank_done=1 next cycle only.
REQ-016 wr_en while !wr_ready, or wr_addr >= DEPTH: write dropped, wcnt unchanged, err set.
REQ-017 Read: rd_en && rd_avail -> rd_data <= mem[rb][rd_addr], rd_valid=1 next cycle (latency 1); else rd_valid=0, rd_data holds.
REQ-018 rd_addr >= DEPTH with rd_en && rd_avail: rd_valid=0, err set.
REQ-019 rd_release && rd_avail: rb->(rb+1) mod NUM_BANKS, fill_level-1; rd_release while !rd_avail: ignored, err set.
REQ-020 rd_en and rd_release same cycle: read served from old rb, then rb advances.
REQ-021 Bank completion and release same cycle: fill_level unchanged, both pointers advance.
REQ-022 Write to a bank and read of same flat address same cycle impossible by construction (wb bank never filled); no bypass required.
REQ-023 clear: wb, rb, wcnt, fill_level, err, bank_done, rd_valid -> 0; memory retained; clear overrides all same-cycle requests.
REQ-024 err SHALL stay 1 until rst or clear.

Reset
REQ-025 rst asserted SHALL immediately force wb=0, rb=0, wcnt=0, fill_level=0, rd_data=0, rd_valid=0, bank_done=0, err=0; hence wr_ready=1, rd_avail=0.
REQ-026 Mid-fill or mid-read rst SHALL discard partial bank and in-flight read; first cycle after release behaves as post-power-up.

Structure
REQ-027 Shared package data_bram_pkg SHALL hold default DATA_WIDTH, DEPTH, NUM_BANKS and width-derivation constants.
REQ-028 Storage SHALL be sub-module bram_sdp (simple dual-port, one write, one registered read port, no reset on array) to guarantee BRAM inference; control in data_bank_bram.

Verification (DEPTH=4, NUM_BANKS=2, DATA_WIDTH=32)
REQ-029 Write 0xA0..0xA3 to addr 0..3 -> bank_done pulse one cycle after 4th write, fill_level=1, rd_avail=1, wr_ready=1.
REQ-030 Fill both banks (8 writes), 9th write 0xFF -> dropped, wr_ready=0, err=1, bank0 addr0 reads 0xA0 one cycle after rd_en.
REQ-031 rd_en addr2 plus rd_release same cycle -> rd_data=0xA2 next cycle, fill_level 2->1, next read returns bank1 data.
REQ-032 4th write of a bank coincident with rd_release at fill_level=1 -> fill_level stays 1, bank_done pulses, both pointers advance.
REQ-033 rst asserted mid-fill after 2 writes -> all outputs reset values immediately; subsequent 4 writes produce bank_done from bank0.
REQ-034 wr_addr=5 and rd_release at fill_level=0 -> no state change, err=1; clear -> err=0, memory contents readable after refill unchanged elsewhere.
